// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, header layout
// and memory depth limits.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_D  = 3'd1,
    ST_LD_I   = 3'd2,
    ST_LD_DLO = 3'd3,
    ST_LD_DHI = 3'd4,
    ST_RUN    = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

  localparam int unsigned IMEM_ADDR_W_DEF = 9;
  localparam int unsigned DMEM_ADDR_W_DEF = 10;
  localparam int unsigned CYC_W_DEF       = 32;

  // Word positions of the two header fields within the stream.
  localparam int unsigned HDR_NI_POS = 0;
  localparam int unsigned HDR_ND_POS = 1;

  localparam logic [31:0] MAX_I = 32'd1 << IMEM_ADDR_W_DEF;
  localparam logic [31:0] MAX_D = 32'd1 << DMEM_ADDR_W_DEF;

  // A count equal to the depth is legal; only strictly larger counts are rejected.
  function automatic logic exceeds_depth(input logic [31:0] count, input int unsigned aw);
    return count > (32'd1 << aw);
  endfunction

endpackage

// File: rtl/prog_loader_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/prog_loader.sv
// Streams a header plus instruction and data images into the cpu memories,
// then releases the core and runs it until halt, counting enabled cycles.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned IMEM_ADDR_W = IMEM_ADDR_W_DEF,
  parameter int unsigned DMEM_ADDR_W = DMEM_ADDR_W_DEF,
  parameter int unsigned CYC_W       = CYC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             halt,
  output logic             cpu_arst_n,
  output logic             cpu_enable,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic [63:0]      wdata_ext_2,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CYC_W-1:0] cycles
);

  // One extra bit so a count equal to the full depth fits.
  localparam int unsigned IW = IMEM_ADDR_W + 1;
  localparam int unsigned DW = DMEM_ADDR_W + 1;
  localparam logic [IW-1:0] ONE_I = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] ONE_D = {{(DW-1){1'b0}}, 1'b1};

  state_e        state_q;
  logic [IW-1:0] n_i_q, idx_i_q;
  logic [DW-1:0] n_d_q, idx_d_q;
  logic [31:0]   lo_q;
  logic          s_ready_q, cpu_arst_n_q, cpu_enable_q;
  logic [63:0]   addr_ext_q, addr_ext_2_q, wdata_ext_2_q;
  logic [31:0]   wdata_ext_q;
  logic          wen_ext_q, wen_ext_2_q;
  logic          busy_q, done_q, err_q;

  logic accept, last_i, last_d, cyc_clr, cyc_inc;

  assign accept = s_valid && s_ready_q;
  assign last_i = (idx_i_q + ONE_I) == n_i_q;
  assign last_d = (idx_d_q + ONE_D) == n_d_q;

  // The first RUN cycle still has the core in reset; that is where the count restarts.
  assign cyc_clr = (state_q == ST_RUN) && !cpu_arst_n_q;
  assign cyc_inc = (state_q == ST_RUN) && cpu_enable_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      n_i_q         <= {IW{1'b0}};
      idx_i_q       <= {IW{1'b0}};
      n_d_q         <= {DW{1'b0}};
      idx_d_q       <= {DW{1'b0}};
      lo_q          <= 32'd0;
      s_ready_q     <= 1'b1;
      cpu_arst_n_q  <= 1'b0;
      cpu_enable_q  <= 1'b0;
      addr_ext_q    <= 64'd0;
      wen_ext_q     <= 1'b0;
      wdata_ext_q   <= 32'd0;
      addr_ext_2_q  <= 64'd0;
      wen_ext_2_q   <= 1'b0;
      wdata_ext_2_q <= 64'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      wen_ext_q   <= 1'b0;
      wen_ext_2_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            cpu_arst_n_q <= 1'b0;
            done_q       <= 1'b0;
            idx_i_q      <= {IW{1'b0}};
            idx_d_q      <= {DW{1'b0}};
            if (exceeds_depth(s_data, IMEM_ADDR_W)) begin
              state_q   <= ST_ERR;
              err_q     <= 1'b1;
              s_ready_q <= 1'b0;
              busy_q    <= 1'b0;
            end else begin
              n_i_q   <= s_data[IW-1:0];
              state_q <= ST_HDR_D;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_HDR_D: begin
          if (accept) begin
            if (exceeds_depth(s_data, DMEM_ADDR_W)) begin
              state_q   <= ST_ERR;
              err_q     <= 1'b1;
              s_ready_q <= 1'b0;
              busy_q    <= 1'b0;
            end else begin
              n_d_q <= s_data[DW-1:0];
              if (n_i_q != {IW{1'b0}}) begin
                state_q <= ST_LD_I;
              end else if (s_data != 32'd0) begin
                state_q <= ST_LD_DLO;
              end else begin
                state_q   <= ST_RUN;
                s_ready_q <= 1'b0;
              end
            end
          end
        end
        ST_LD_I: begin
          if (accept) begin
            wen_ext_q   <= 1'b1;
            addr_ext_q  <= {{(62-IW){1'b0}}, idx_i_q, 2'b00};
            wdata_ext_q <= s_data;
            idx_i_q     <= idx_i_q + ONE_I;
            if (last_i) begin
              if (n_d_q != {DW{1'b0}}) begin
                state_q <= ST_LD_DLO;
              end else begin
                state_q   <= ST_RUN;
                s_ready_q <= 1'b0;
              end
            end
          end
        end
        ST_LD_DLO: begin
          if (accept) begin
            lo_q    <= s_data;
            state_q <= ST_LD_DHI;
          end
        end
        ST_LD_DHI: begin
          if (accept) begin
            wen_ext_2_q   <= 1'b1;
            addr_ext_2_q  <= {{(61-DW){1'b0}}, idx_d_q, 3'b000};
            wdata_ext_2_q <= {s_data, lo_q};
            idx_d_q       <= idx_d_q + ONE_D;
            if (last_d) begin
              state_q   <= ST_RUN;
              s_ready_q <= 1'b0;
            end else begin
              state_q <= ST_LD_DLO;
            end
          end
        end
        // Release is delayed one cycle so the final memory write lands before the core starts.
        ST_RUN: begin
          if (halt) begin
            state_q      <= ST_DONE;
            cpu_enable_q <= 1'b0;
            cpu_arst_n_q <= 1'b1;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            s_ready_q    <= 1'b1;
          end else if (!cpu_enable_q) begin
            cpu_enable_q <= 1'b1;
            cpu_arst_n_q <= 1'b1;
          end
        end
        ST_ERR: begin
          state_q <= ST_ERR;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  sat_counter #(.W(CYC_W)) u_cycles (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cyc_clr),
    .inc_i (cyc_inc),
    .cnt_o (cycles)
  );

  assign s_ready     = s_ready_q;
  assign cpu_arst_n  = cpu_arst_n_q;
  assign cpu_enable  = cpu_enable_q;
  assign addr_ext    = addr_ext_q;
  assign wen_ext     = wen_ext_q;
  assign wdata_ext   = wdata_ext_q;
  assign addr_ext_2  = addr_ext_2_q;
  assign wen_ext_2   = wen_ext_2_q;
  assign wdata_ext_2 = wdata_ext_2_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued as words
// are streamed in and matched against the write strobes the loader produces.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst, s_valid, s_ready, halt;
  logic [31:0] s_data;
  logic        cpu_arst_n, cpu_enable, wen_ext, wen_ext_2, busy, done, err;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
  logic [31:0] wdata_ext, cycles;

  typedef struct packed {
    logic        d;
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] prog_i[$];
  logic [63:0] prog_d[$];
  logic [31:0] hdr[2];
  int          checks = 0;
  int          errors = 0;

  prog_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .halt(halt), .cpu_arst_n(cpu_arst_n), .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .wdata_ext_2(wdata_ext_2),
    .busy(busy), .done(done), .err(err), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (wen_ext || wen_ext_2)) begin
      wr_t e;
      check("wen_excl", 64'(wen_ext & wen_ext_2), 64'd0);
      check("en_during_wr", 64'(cpu_enable), 64'd0);
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wr_port", 64'(wen_ext_2), 64'(e.d));
        check("wr_addr", wen_ext_2 ? addr_ext_2 : addr_ext, e.addr);
        check("wr_data", wen_ext_2 ? wdata_ext_2 : {32'd0, wdata_ext}, e.data);
      end
    end
  end

  task automatic push_wr(input logic d, input logic [63:0] addr, input logic [63:0] data);
    wr_t e;
    e.d = d; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  // Called at a falling edge; returns at the falling edge after the word is taken.
  task automatic send(input logic [31:0] w, input int gap);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("ready_timeout", 64'(t < 40), 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = $urandom;
    repeat (gap) @(negedge clk);
  endtask

  task automatic load(input int gap);
    hdr[HDR_NI_POS] = 32'(prog_i.size());
    hdr[HDR_ND_POS] = 32'(prog_d.size());
    send(hdr[HDR_NI_POS], gap);
    check("hdr_state", 64'({cpu_arst_n, done, busy, err}), 64'(4'b0010));
    send(hdr[HDR_ND_POS], gap);
    for (int i = 0; i < prog_i.size(); i++) begin
      push_wr(1'b0, 64'(i) * 64'd4, {32'd0, prog_i[i]});
      send(prog_i[i], gap);
    end
    for (int i = 0; i < prog_d.size(); i++) begin
      send(prog_d[i][31:0], gap);
      push_wr(1'b1, 64'(i) * 64'd8, prog_d[i]);
      send(prog_d[i][63:32], gap);
    end
  endtask

  task automatic wait_en();
    int t;
    t = 0;
    while (!cpu_enable && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("en_timeout", 64'(t < 20), 64'd1);
    check("run_arst", 64'(cpu_arst_n), 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_halt();
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check("halt_done", 64'({done, busy, cpu_enable, cpu_arst_n, s_ready}), 64'(5'b10011));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    halt = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 32'd0; halt = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(s_ready), 64'd1);
    check("rst_cpu", 64'({cpu_arst_n, cpu_enable}), 64'd0);
    check("rst_wen", 64'({wen_ext, wen_ext_2}), 64'd0);
    check("rst_addr", addr_ext | addr_ext_2, 64'd0);
    check("rst_wdata", wdata_ext_2 | {32'd0, wdata_ext}, 64'd0);
    check("rst_flags", 64'({busy, done, err}), 64'd0);
    check("rst_cycles", 64'(cycles), 64'd0);
    rst = 1'b0;

    halt = 1'b1;
    repeat (2) @(negedge clk);
    halt = 1'b0;
    check("halt_idle", 64'({busy, done, cpu_enable, s_ready}), 64'(4'b0001));

    // Reference stream, back to back.
    prog_i = '{32'h0050_0093, 32'h00a0_0113};
    prog_d = '{64'd5};
    load(0);
    check("run_entry", 64'({s_ready, busy, cpu_enable, cpu_arst_n}), 64'(4'b0100));
    wait_en();
    repeat (3) @(negedge clk);
    do_halt();

    // Same stream with gaps, restarted from DONE.
    load(1);
    wait_en();
    do_halt();

    // Empty image runs immediately; halt after ten enabled cycles.
    prog_i = {};
    prog_d = {};
    load(0);
    check("run_entry0", 64'({s_ready, busy, cpu_enable, cpu_arst_n}), 64'(4'b0100));
    wait_en();
    repeat (9) @(negedge clk);
    do_halt();
    check("cycles10", 64'(cycles), 64'd10);
    repeat (3) @(negedge clk);
    check("cycles_frozen", 64'(cycles), 64'd10);

    // Reset partway through the instruction image, then reload cleanly.
    send(32'd3, 0);
    send(32'd0, 0);
    push_wr(1'b0, 64'd0, 64'h0000_0000_dead_beef);
    send(32'hdead_beef, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 64'({s_ready, busy, done, err}), 64'(4'b1000));
    check("mid_rst_wdata", 64'(wdata_ext), 64'd0);
    check("mid_rst_cycles", 64'(cycles), 64'd0);
    check("mid_rst_cpu", 64'({cpu_arst_n, cpu_enable}), 64'd0);
    rst = 1'b0;
    sb.delete();
    prog_i = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    prog_d = '{64'h8765_4321_0fed_cba9};
    load(0);
    wait_en();
    do_halt();

    // Full-depth images on both memories.
    prog_i = {};
    prog_d = {};
    for (int i = 0; i < int'(MAX_I); i++) prog_i.push_back($urandom);
    for (int i = 0; i < int'(MAX_D); i++) prog_d.push_back({$urandom, $urandom});
    load(0);
    wait_en();
    do_halt();

    // Oversized instruction count is fatal and sticky.
    do_reset();
    send(MAX_I + 32'd1, 0);
    check("err_i", 64'({err, s_ready, busy, cpu_arst_n}), 64'(4'b1000));
    s_valid = 1'b1;
    s_data  = 32'd1;
    repeat (5) @(negedge clk);
    s_valid = 1'b0;
    check("err_sticky", 64'({err, s_ready, cpu_enable, cpu_arst_n}), 64'(4'b1000));
    check("err_no_wr", 64'(sb.size()), 64'd0);
    do_reset();
    check("err_cleared", 64'({err, s_ready}), 64'(2'b01));

    // Oversized data count is also rejected.
    send(32'd1, 0);
    send(MAX_D + 32'd1, 0);
    check("err_d", 64'({err, s_ready, busy}), 64'(3'b100));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
